// File: rtl/icache_fill_ctrl_if.sv
// Bus bundle for icache_fill_ctrl: req/ack read port to external word memory plus the
// instruction-cache write port. The controller uses the master modport.
interface icache_fill_ctrl_if #(
  parameter int unsigned ADDR_W = 5
) ();
  logic              mem_req;
  logic [31:0]       mem_addr;
  logic              mem_ack;
  logic [31:0]       mem_rdata;
  logic              ic_we;
  logic [ADDR_W-1:0] ic_addr;
  logic [31:0]       ic_wdata;

  modport master (
    output mem_req, mem_addr, ic_we, ic_addr, ic_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_addr, ic_we, ic_addr, ic_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/icache_fill_ctrl.sv
// Boot/reload sequencer: copies DEPTH words from external memory into the instruction cache
// and holds the CPU until the copy completes. ICACHE_FILL_TIMEOUT_EN adds a per-word ack timeout.
module icache_fill_ctrl #(
  parameter int unsigned DEPTH     = 32,
  parameter int unsigned ADDR_W    = 5,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned TIMEOUT   = 16
) (
  input  logic               CLOCK_50,
  input  logic               RESET,
  input  logic               start,
  icache_fill_ctrl_if.master bus,
  output logic               cpu_hold,
  output logic               busy,
  output logic               done,
  output logic               err
);

  localparam int unsigned IdxW = ADDR_W + 1;

  typedef enum logic [2:0] {StIdle, StReq, StWrite, StDone, StErr} state_e;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic              mem_req_q, mem_req_d;
  logic [31:0]       mem_addr_q, mem_addr_d;
  logic              ic_we_q, ic_we_d;
  logic [ADDR_W-1:0] ic_addr_q, ic_addr_d;
  logic [31:0]       ic_wdata_q, ic_wdata_d;
  logic              cpu_hold_q, cpu_hold_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

`ifdef ICACHE_FILL_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] wait_q, wait_d;
  logic          err_q, err_d;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
`endif

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    mem_addr_d = mem_addr_q;
    ic_addr_d  = ic_addr_q;
    ic_wdata_d = ic_wdata_q;

    unique case (state_q)
      StIdle, StDone, StErr: begin
        if (start) begin
          idx_d   = '0;
          state_d = StReq;
        end
      end
      StReq: begin
        if (bus.mem_ack) begin
          ic_wdata_d = bus.mem_rdata;
          ic_addr_d  = idx_q[ADDR_W-1:0];
          state_d    = StWrite;
        end
`ifdef ICACHE_FILL_TIMEOUT_EN
        // Ack on the final allowed cycle wins over the timeout.
        else if (wait_q == TW'(TIMEOUT - 1)) begin
          state_d = StErr;
        end
`endif
      end
      StWrite: begin
        idx_d   = idx_q + IdxW'(1);
        state_d = (idx_d == IdxW'(DEPTH)) ? StDone : StReq;
      end
      default: state_d = StIdle;
    endcase

    // Address is computed once on REQ entry so it stays stable through wait states.
    if (state_d == StReq && state_q != StReq) begin
      mem_addr_d = BASE_ADDR + (32'(idx_d) << 2);
    end

    mem_req_d  = (state_d == StReq);
    ic_we_d    = (state_d == StWrite);
    busy_d     = (state_d == StReq) || (state_d == StWrite);
    done_d     = (state_d == StDone);
    cpu_hold_d = (state_d != StDone);

`ifdef ICACHE_FILL_TIMEOUT_EN
    wait_d = (state_q == StReq && state_d == StReq) ? wait_q + TW'(1) : '0;
    err_d  = (state_d == StErr);
`endif
  end

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= BASE_ADDR;
      ic_we_q    <= 1'b0;
      ic_addr_q  <= '0;
      ic_wdata_q <= '0;
      cpu_hold_q <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      ic_we_q    <= ic_we_d;
      ic_addr_q  <= ic_addr_d;
      ic_wdata_q <= ic_wdata_d;
      cpu_hold_q <= cpu_hold_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

`ifdef ICACHE_FILL_TIMEOUT_EN
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      wait_q <= '0;
      err_q  <= 1'b0;
    end else begin
      wait_q <= wait_d;
      err_q  <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign bus.mem_req  = mem_req_q;
  assign bus.mem_addr = mem_addr_q;
  assign bus.ic_we    = ic_we_q;
  assign bus.ic_addr  = ic_addr_q;
  assign bus.ic_wdata = ic_wdata_q;
  assign cpu_hold     = cpu_hold_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_icache_fill_ctrl.sv
// Scoreboard bench for icache_fill_ctrl: a word-memory model pushes each acked word as the
// expected cache write; a write monitor pops and compares. Fill latencies are timed from start.
module tb_icache_fill_ctrl;
  localparam int unsigned DEPTH   = 32;
  localparam int unsigned ADDR_W  = 5;
  localparam int unsigned TIMEOUT = 16;
  localparam logic [31:0] BASE    = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic cpu_hold, busy, done, err;

  icache_fill_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  icache_fill_ctrl #(
    .DEPTH    (DEPTH),
    .ADDR_W   (ADDR_W),
    .BASE_ADDR(BASE),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .CLOCK_50(clk),
    .RESET   (rst),
    .start   (start),
    .bus     (bus),
    .cpu_hold(cpu_hold),
    .busy    (busy),
    .done    (done),
    .err     (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  int mem_delay = 0;
  int hang_idx = -1;
  int addr8_cycles = 0;
  int we_count = 0;
  logic [31:0] last_wdata = '0;
  logic [ADDR_W+31:0] sb_q[$];

  // Memory model: acks after mem_delay idle REQ cycles, never acks word hang_idx.
  initial begin : mem_model
    int widx;
    int wait_cnt;
    logic [31:0] data;
    wait_cnt = 0;
    bus.mem_ack = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      bus.mem_ack = 1'b0;
      if (bus.mem_req && !rst) begin
        widx = int'((bus.mem_addr - BASE) >> 2);
        if (bus.mem_addr == 32'h0000_0008) addr8_cycles++;
        if (widx != hang_idx && wait_cnt >= mem_delay) begin
          data = 32'hA5A5_0000 + 32'(widx);
          bus.mem_ack = 1'b1;
          bus.mem_rdata = data;
          sb_q.push_back({ADDR_W'(widx), data});
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  initial begin : wr_mon
    logic [ADDR_W+31:0] exp;
    forever begin
      @(negedge clk);
      if (bus.ic_we) begin
        we_count++;
        last_wdata = bus.ic_wdata;
        if (sb_q.size() == 0) begin
          check("we_unexpected", 32'd1, 32'd0);
        end else begin
          exp = sb_q.pop_front();
          check("ic_addr", 32'(bus.ic_addr), 32'(exp[ADDR_W+31:32]));
          check("ic_wdata", bus.ic_wdata, exp[31:0]);
        end
      end
    end
  end

  // Pulse start so that the following posedge (E0) samples it; returns 1 ns after E0.
  task automatic start_fill();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // cyc = edges after E0 before the flag is seen; flag at cyc N is sampled at edge E0+N+1.
  task automatic wait_flag(input int pulse_at, input bit on_err, output int cyc);
    cyc = 0;
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      start = (pulse_at >= 0) && (cyc == pulse_at || cyc == pulse_at + 1);
      if (on_err ? err : done) begin
        start = 1'b0;
        return;
      end
      @(posedge clk);
      cyc++;
    end
    start = 1'b0;
    check("wait_budget", 32'd1, 32'd0);
    cyc = -1;
  endtask

  task automatic check_done(input string tag, input int cyc, input int exp_cyc, input int writes);
    check({tag, "_latency"}, 32'(cyc), 32'(exp_cyc));
    check({tag, "_writes"}, 32'(writes), DEPTH);
    check({tag, "_last_word"}, last_wdata, 32'hA5A5_0000 + DEPTH - 1);
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_hold"}, 32'(cpu_hold), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
    check({tag, "_sb_empty"}, 32'(sb_q.size()), 32'd0);
  endtask

  initial begin : main
    int cyc;
    int we0;
    int a80;
    rst = 1'b1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_mem_req", 32'(bus.mem_req), 32'd0);
    check("rst_mem_addr", bus.mem_addr, BASE);
    check("rst_ic_we", 32'(bus.ic_we), 32'd0);
    check("rst_ic_addr", 32'(bus.ic_addr), 32'd0);
    check("rst_ic_wdata", bus.ic_wdata, 32'd0);
    check("rst_hold", 32'(cpu_hold), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    rst = 1'b0;

    // Zero-wait fill: done visible at edge E0+65.
    we0 = we_count;
    start_fill();
    check("zw_req_rise", 32'(bus.mem_req), 32'd1);
    check("zw_busy", 32'(busy), 32'd1);
    check("zw_addr0", bus.mem_addr, BASE);
    wait_flag(-1, 1'b0, cyc);
    check_done("zw", cyc, 2 * DEPTH, we_count - we0);

    // Three wait states per word.
    mem_delay = 3;
    a80 = addr8_cycles;
    we0 = we_count;
    start_fill();
    check("dly_hold_rise", 32'(cpu_hold), 32'd1);
    check("dly_done_fall", 32'(done), 32'd0);
    wait_flag(-1, 1'b0, cyc);
    check_done("dly", cyc, 5 * DEPTH, we_count - we0);
    check("dly_addr8_cycles", 32'(addr8_cycles - a80), 32'd4);
    mem_delay = 0;

    // start pulses during REQ/WRITE of idx 10 are ignored.
    we0 = we_count;
    start_fill();
    wait_flag(20, 1'b0, cyc);
    check_done("mid", cyc, 2 * DEPTH, we_count - we0);

    // Reset during WRITE of idx 7, then a full refill.
    we0 = we_count;
    start_fill();
    repeat (15) @(posedge clk);
    @(negedge clk);
    check("rstw_in_write", 32'(bus.ic_we), 32'd1);
    check("rstw_idx7", 32'(bus.ic_addr), 32'd7);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rstw_ic_we", 32'(bus.ic_we), 32'd0);
    check("rstw_hold", 32'(cpu_hold), 32'd1);
    check("rstw_busy", 32'(busy), 32'd0);
    check("rstw_mem_req", 32'(bus.mem_req), 32'd0);
    check("rstw_mem_addr", bus.mem_addr, BASE);
    check("rstw_writes", 32'(we_count - we0), 32'd8);
    rst = 1'b0;
    we0 = we_count;
    start_fill();
    wait_flag(-1, 1'b0, cyc);
    check_done("refill", cyc, 2 * DEPTH, we_count - we0);

    // start while in DONE: hold rises at once, then another full fill.
    we0 = we_count;
    start_fill();
    check("redo_hold", 32'(cpu_hold), 32'd1);
    check("redo_done", 32'(done), 32'd0);
    check("redo_req", 32'(bus.mem_req), 32'd1);
    wait_flag(-1, 1'b0, cyc);
    check_done("redo", cyc, 2 * DEPTH, we_count - we0);

`ifdef ICACHE_FILL_TIMEOUT_EN
    // Word 5 never acked: ERR after TIMEOUT REQ cycles, then retry from BASE.
    hang_idx = 5;
    we0 = we_count;
    start_fill();
    wait_flag(-1, 1'b1, cyc);
    check("to_latency", 32'(cyc), 32'(2 * 5 + TIMEOUT));
    check("to_err", 32'(err), 32'd1);
    check("to_mem_req", 32'(bus.mem_req), 32'd0);
    check("to_hold", 32'(cpu_hold), 32'd1);
    check("to_done", 32'(done), 32'd0);
    check("to_writes", 32'(we_count - we0), 32'd5);
    hang_idx = -1;
    we0 = we_count;
    start_fill();
    check("retry_addr", bus.mem_addr, BASE);
    check("retry_req", 32'(bus.mem_req), 32'd1);
    check("retry_err", 32'(err), 32'd0);
    wait_flag(-1, 1'b0, cyc);
    check_done("retry", cyc, 2 * DEPTH, we_count - we0);
`endif

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
